id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage CPU. It latches the register-file read data (busA/busB) and the decoded control, immediate and PC of the ID-stage instruction. It computes and registers EX-stage forwarding selects and detects load-use hazards, requesting a one-cycle stall and inserting a bubble. It also honours a branch flush from EX and a global freeze from MEM.

Parameters:
CTRL_W, 12, width of the opaque decoded control bundle passed to EX
XLEN, 32, datapath width

Ports:
clk  in  1  pipeline clock, rising-edge registers
rst  in  1  asynchronous, active-low reset
freeze  in  1  global hold from MEM; all state holds
flush  in  1  branch/jump taken in EX; kill ID/EX contents
id_valid  in  1  ID holds a real instruction
id_ra, id_rb  in  5  source register numbers, same as driven to register file
id_uses_a, id_uses_b  in  1  instruction actually reads ra / rb
id_rw  in  5  destination register
id_wen  in  1  instruction writes rw
id_memrd, id_memwr  in  1  load / store
id_ctrl  in  CTRL_W  decoded ALU/mux control
id_imm, id_pc  in  XLEN  extended immediate, instruction PC
busA, busB  in  XLEN  register-file read data (already reflects same-cycle WB write)
exmem_rw  in  5  destination of the instruction currently in MEM
exmem_wen  in  1  its write enable
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid, ex_wen, ex_memrd, ex_memwr  out  1  registered control
ex_rw  out  5  registered destination
ex_ctrl  out  CTRL_W  registered control bundle
ex_a, ex_b, ex_imm, ex_pc  out  XLEN  registered operands, immediate, PC
ex_fwd_a, ex_fwd_b  out  2  EX operand select: 00 ex_a/ex_b, 01 EX/MEM result, 10 MEM/WB result

Behaviour:
- Reset (rst=0, async): every output register is 0, giving a bubble.
- Bubble definition: ex_valid=ex_wen=ex_memrd=ex_memwr=0, ex_ctrl=0, ex_rw=0, ex_fwd_*=00. Data fields are don't-care but driven to 0.
- Hazard terms are evaluated on the current ID inputs against the current ID/EX contents ("one ahead") and exmem_* ("two ahead"):
  - match1_x = id_uses_x & ex_valid & ex_wen & (ex_rw==id_rx) & (id_rx!=0)
  - match2_x = id_uses_x & exmem_wen & (exmem_rw==id_rx) & (id_rx!=0)
- Load-use: stall = id_valid & ex_memrd & (match1_a | match1_b) & ~flush.
- Forward select for operand x: 01 if match1_x, else 10 if match2_x, else 00. The nearest producer wins.
- Instructions three ahead are not forwarded; the register file's write-then-read makes busA/busB correct.
- Update priority at each rising clk:
  1. freeze=1: hold all registers. stall is still computed but is irrelevant.
  2. flush=1: load bubble. Flush overrides stall.
  3. stall=1: load bubble. The ID instruction is held upstream and re-evaluated next cycle, when the load is two ahead and the select becomes 10.
  4. id_valid=0: load bubble.
  5. Otherwise: latch all id_* fields, busA, busB and the computed selects. ex_valid=1.
- Latency: 1 cycle from ID inputs to ex_* outputs. A load-use pair costs exactly 1 bubble.
- rd/rw=0 never matches, so $zero is never forwarded or stalled on.
- A store that only uses rb (id_uses_a=0) does not stall on ra matches.
- Reset mid-stall: outputs clear immediately; stall deasserts because ex_memrd=0.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle -> all ex_* = 0 and stall=0 immediately.
- Back-to-back ALU dependency: add r3 followed by sub using ra=r3 -> second instruction latched with ex_fwd_a=01, no stall. A third instruction using r3 gets ex_fwd_a=10.
- Load-use: lw r5 then add ra=r5 -> stall=1 for one cycle, one bubble (ex_valid=0) enters EX. Next cycle the add is latched with ex_fwd_a=10 and stall=0.
- Zero register: producer rw=0, wen=1, consumer ra=0 -> ex_fwd_a=00, stall=0.
- Flush during load-use: flush=1 in the stall cycle -> bubble latched and stall=0. Freeze=1 for 3 cycles with valid contents -> all outputs unchanged, then the pipeline resumes.
- Both operands: ra matches one-ahead and rb matches exmem_rw -> ex_fwd_a=01, ex_fwd_b=10. busA=0x12345678 is latched into ex_a unmodified.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Latches the ID-stage instruction (operands, control, immediate, PC) for EX,
// computes registered EX forwarding selects and detects load-use hazards.
//
// Flow control: freeze from MEM holds every register. flush from EX or a
// load-use stall loads a bubble. stall is combinational and tells IF/ID to
// hold the same instruction so it is re-evaluated next cycle, once the load
// has moved on to MEM.
module id_ex_stage #(
   parameter int CTRL_W = 12,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [4:0]        id_ra,
   input  logic [4:0]        id_rb,
   input  logic              id_uses_a,
   input  logic              id_uses_b,
   input  logic [4:0]        id_rw,
   input  logic              id_wen,
   input  logic              id_memrd,
   input  logic              id_memwr,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   busA,
   input  logic [XLEN-1:0]   busB,
   input  logic [4:0]        exmem_rw,
   input  logic              exmem_wen,
   output logic              stall,
   output logic              ex_valid,
   output logic              ex_wen,
   output logic              ex_memrd,
   output logic              ex_memwr,
   output logic [4:0]        ex_rw,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_a,
   output logic [XLEN-1:0]   ex_b,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b
);

   // Pipeline registers
   logic              r_valid;
   logic              r_wen;
   logic              r_memrd;
   logic              r_memwr;
   logic [4:0]        r_rw;
   logic [CTRL_W-1:0] r_ctrl;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic [XLEN-1:0]   r_imm;
   logic [XLEN-1:0]   r_pc;
   logic [1:0]        r_fwd_a;
   logic [1:0]        r_fwd_b;

   // Hazard terms
   logic       w_match1_a;
   logic       w_match1_b;
   logic       w_match2_a;
   logic       w_match2_b;
   logic       w_stall;
   logic       w_bubble;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // Compare ID sources against the instruction one ahead (ID/EX) and two
   // ahead (EX/MEM); register 0 never matches. Nearest producer wins.
   always_comb begin
      w_match1_a = id_uses_a & r_valid & r_wen & (r_rw == id_ra) & (id_ra != 5'd0);
      w_match1_b = id_uses_b & r_valid & r_wen & (r_rw == id_rb) & (id_rb != 5'd0);
      w_match2_a = id_uses_a & exmem_wen & (exmem_rw == id_ra) & (id_ra != 5'd0);
      w_match2_b = id_uses_b & exmem_wen & (exmem_rw == id_rb) & (id_rb != 5'd0);
      w_stall    = id_valid & r_memrd & (w_match1_a | w_match1_b) & ~flush;
      w_bubble   = flush | w_stall | ~id_valid;
      w_fwd_a    = 2'b00;
      w_fwd_b    = 2'b00;
      if (w_match1_a)      w_fwd_a = 2'b01;
      else if (w_match2_a) w_fwd_a = 2'b10;
      if (w_match1_b)      w_fwd_b = 2'b01;
      else if (w_match2_b) w_fwd_b = 2'b10;
   end

   // Register update: freeze holds, flush/stall/no-instruction load a bubble,
   // otherwise latch the ID instruction and its forwarding selects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_wen   <= 1'b0;
         r_memrd <= 1'b0;
         r_memwr <= 1'b0;
         r_rw    <= 5'd0;
         r_ctrl  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (freeze) begin
         r_valid <= r_valid;
      end else if (w_bubble) begin
         r_valid <= 1'b0;
         r_wen   <= 1'b0;
         r_memrd <= 1'b0;
         r_memwr <= 1'b0;
         r_rw    <= 5'd0;
         r_ctrl  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else begin
         r_valid <= 1'b1;
         r_wen   <= id_wen;
         r_memrd <= id_memrd;
         r_memwr <= id_memwr;
         r_rw    <= id_rw;
         r_ctrl  <= id_ctrl;
         r_a     <= busA;
         r_b     <= busB;
         r_imm   <= id_imm;
         r_pc    <= id_pc;
         r_fwd_a <= w_fwd_a;
         r_fwd_b <= w_fwd_b;
      end
   end

   assign stall    = w_stall;
   assign ex_valid = r_valid;
   assign ex_wen   = r_wen;
   assign ex_memrd = r_memrd;
   assign ex_memwr = r_memwr;
   assign ex_rw    = r_rw;
   assign ex_ctrl  = r_ctrl;
   assign ex_a     = r_a;
   assign ex_b     = r_b;
   assign ex_imm   = r_imm;
   assign ex_pc    = r_pc;
   assign ex_fwd_a = r_fwd_a;
   assign ex_fwd_b = r_fwd_b;

endmodule
